// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART frame timing constants and arbiter state encoding
package uart_pkg;

  localparam int UART_CLKS_PER_BIT   = 400;
  localparam int UART_BITS_PER_FRAME = 10;
  localparam int UART_FRAME_CYCLES   = UART_CLKS_PER_BIT * UART_BITS_PER_FRAME;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_HOLD  = 2'd2
  } arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin priority picker
module rr_pick #(
  parameter int N_REQ = 4
) (
  input  logic [N_REQ-1:0] req,
  input  logic [2:0]       last_grant,
  output logic             valid,
  output logic [2:0]       winner
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [IDX_W-1:0] idx;

  // Scan upward from last_grant+1 with wrap; the first requester found wins.
  always_comb begin
    valid  = 1'b0;
    winner = '0;
    idx    = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      idx = IDX_W'((int'(last_grant) + k) % N_REQ);
      if (!valid && req[idx]) begin
        valid  = 1'b1;
        winner = 3'(idx);
      end
    end
  end

endmodule

// File: rtl/uart_tx_arb.sv
// rtl/uart_tx_arb.sv - round-robin byte scheduler in front of a single uart_tx
module uart_tx_arb
  import uart_pkg::*;
#(
  parameter int N_REQ        = 4,
  parameter int FRAME_CYCLES = UART_FRAME_CYCLES,
  parameter int GAP_CYCLES   = 2
) (
  input  logic               sys_clk,
  input  logic               sys_rst_n,
  input  logic               arb_en,
  input  logic [N_REQ-1:0]   req,
  input  logic [8*N_REQ-1:0] req_data,
  output logic [N_REQ-1:0]   ack,
  output logic [7:0]         tx_din,
  output logic               tx_send_start,
  output logic               tx_busy,
  output logic [2:0]         last_grant
);

  // The hold-off counter is 16 bits wide, so the frame plus guard must fit.
  if (FRAME_CYCLES + GAP_CYCLES > 65535) begin : g_hold_range
    $error("uart_tx_arb: FRAME_CYCLES+GAP_CYCLES exceeds 16-bit hold counter");
  end

  localparam logic [15:0] HOLD_LAST = 16'(FRAME_CYCLES + GAP_CYCLES - 1);

  arb_state_t  state;
  logic [15:0] hold_cnt;
  logic        pick_valid;
  logic [2:0]  pick_winner;
  logic [7:0]  din_sel;

  rr_pick #(.N_REQ(N_REQ)) u_rr_pick (
    .req        (req),
    .last_grant (last_grant),
    .valid      (pick_valid),
    .winner     (pick_winner)
  );

  // Select the winning requester's byte for capture at the grant edge.
  always_comb begin
    din_sel = 8'h00;
    for (int i = 0; i < N_REQ; i++) begin
      if (pick_winner == 3'(i)) din_sel = req_data[8*i +: 8];
    end
  end

  // Grant FSM: IDLE picks a winner, START pulses send_start/ack, HOLD times the frame plus guard.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state         <= ST_IDLE;
      hold_cnt      <= '0;
      ack           <= '0;
      tx_din        <= 8'h00;
      tx_send_start <= 1'b0;
      tx_busy       <= 1'b0;
      last_grant    <= 3'(N_REQ - 1);
    end else begin
      ack           <= '0;
      tx_send_start <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (arb_en && pick_valid) begin
            state         <= ST_START;
            ack           <= N_REQ'(1) << pick_winner;
            tx_send_start <= 1'b1;
            tx_din        <= din_sel;
            last_grant    <= pick_winner;
            tx_busy       <= 1'b1;
            hold_cnt      <= '0;
          end
        end
        ST_START: begin
          state <= ST_HOLD;
        end
        ST_HOLD: begin
          if (hold_cnt == HOLD_LAST) begin
            state    <= ST_IDLE;
            tx_busy  <= 1'b0;
            hold_cnt <= '0;
          end else begin
            hold_cnt <= hold_cnt + 16'd1;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
